// File: rtl/quad_cmd_pkg.sv
// Shared opcodes, response codes, queue entry layout and sequencer state
// encoding for the ground-side QuadCopter command path.
package quad_cmd_pkg;

   localparam logic [7:0] REQ_BATT  = 8'h01;
   localparam logic [7:0] SET_PTCH  = 8'h02;
   localparam logic [7:0] SET_ROLL  = 8'h03;
   localparam logic [7:0] SET_YAW   = 8'h04;
   localparam logic [7:0] SET_THRST = 8'h05;
   localparam logic [7:0] CALIBRATE = 8'h06;
   localparam logic [7:0] EMER_LAND = 8'h07;
   localparam logic [7:0] MTRS_OFF  = 8'h08;

   localparam logic [7:0]  ACK     = 8'hA5;
   localparam logic [15:0] NO_DATA = 16'h0000;

   typedef struct packed {
      logic [7:0]  cmd;
      logic [15:0] data;
   } cmd_entry_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_WAIT_RESP,
      S_CLR,
      S_RETIRE
   } seq_state_e;

   // Battery requests return a reading rather than an ACK, so any byte counts.
   function automatic logic is_success(input logic [7:0] op, input logic [7:0] rsp);
      return (op == REQ_BATT) || (rsp == ACK);
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Circular FIFO with one extra wrap bit per pointer to tell full from empty.
// A push while full is dropped regardless of a simultaneous pop.
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             wr_en;
   logic             rd_en;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign wr_en   = push_i && !full_o;
   assign rd_en   = pop_i && !empty_o;

   assign wr_ptr_d  = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
   assign rd_ptr_d  = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is deliberately not reset; empty pointers already mask
   // stale contents, and leaving it reset-free lets it map onto RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
   end

endmodule

// File: rtl/cmd_sequencer.sv
// Queues command/data pairs and drives them one at a time through CommMaster,
// checking ACK/NAK, retrying on failure or timeout, and reporting completion.
module cmd_sequencer
   import quad_cmd_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int TMO_CYCLES = 1_000_000,
   parameter int MAX_RETRY  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic [7:0]  push_cmd,
   input  logic [15:0] push_data,
   output logic        full,
   output logic        busy,
   output logic        snd_cmd,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   input  logic        frm_snt,
   input  logic        resp_rdy,
   input  logic [7:0]  resp,
   output logic        clr_resp_rdy,
   output logic        done,
   output logic [7:0]  done_cmd,
   output logic [7:0]  done_resp,
   output logic        done_err
);

   localparam int TW = $clog2(TMO_CYCLES + 1);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   seq_state_e  state_q, state_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [15:0] data_q, data_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]  resp_q, resp_d;
   logic        tmo_hit_q, tmo_hit_d;
   logic        snd_cmd_q, snd_cmd_d;
   logic        clr_q, clr_d;
   logic        done_q, done_d;
   logic [7:0]  done_cmd_q, done_cmd_d;
   logic [7:0]  done_resp_q, done_resp_d;
   logic        done_err_q, done_err_d;

   cmd_entry_t  head;
   logic        fifo_empty;
   logic        fifo_full;
   logic        pop;

   // Frame-sent is observed for debug only; it never gates the response wait.
   logic unused_frm_snt;
   assign unused_frm_snt = frm_snt;

   cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(cmd_entry_t))
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (push),
      .wr_data_i ({push_cmd, push_data}),
      .pop_i     (pop),
      .rd_data_o (head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      data_d      = data_q;
      retry_d     = retry_q;
      tmo_d       = tmo_q;
      resp_d      = resp_q;
      tmo_hit_d   = tmo_hit_q;
      done_cmd_d  = done_cmd_q;
      done_resp_d = done_resp_q;
      done_err_d  = done_err_q;
      pop         = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!fifo_empty) state_d = S_LOAD;
         end
         S_LOAD: begin
            pop     = 1'b1;
            cmd_d   = head.cmd;
            data_d  = head.data;
            retry_d = '0;
            state_d = S_SEND;
         end
         S_SEND: begin
            tmo_d   = '0;
            state_d = S_WAIT_RESP;
         end
         S_WAIT_RESP: begin
            tmo_d = (tmo_q == TW'(TMO_CYCLES)) ? tmo_q : tmo_q + 1'b1;
            if (resp_rdy) begin
               resp_d    = resp;
               tmo_hit_d = 1'b0;
               state_d   = S_CLR;
            end else if (tmo_q >= TW'(TMO_CYCLES - 1)) begin
               resp_d    = 8'h00;
               tmo_hit_d = 1'b1;
               state_d   = S_CLR;
            end
         end
         S_CLR: begin
            if (!tmo_hit_q && is_success(cmd_q, resp_q)) begin
               done_err_d = 1'b0;
               state_d    = S_RETIRE;
            end else if (retry_q < RW'(MAX_RETRY)) begin
               retry_d = retry_q + 1'b1;
               state_d = S_SEND;
            end else begin
               done_err_d = 1'b1;
               state_d    = S_RETIRE;
            end
            if (state_d == S_RETIRE) begin
               done_cmd_d  = cmd_q;
               done_resp_d = resp_q;
            end
         end
         S_RETIRE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Pulses are decoded from the next state so they coincide with the state.
      snd_cmd_d = (state_d == S_SEND);
      clr_d     = (state_d == S_CLR);
      done_d    = (state_d == S_RETIRE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cmd_q       <= 8'h00;
         data_q      <= NO_DATA;
         retry_q     <= '0;
         tmo_q       <= '0;
         resp_q      <= 8'h00;
         tmo_hit_q   <= 1'b0;
         snd_cmd_q   <= 1'b0;
         clr_q       <= 1'b0;
         done_q      <= 1'b0;
         done_cmd_q  <= 8'h00;
         done_resp_q <= 8'h00;
         done_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         data_q      <= data_d;
         retry_q     <= retry_d;
         tmo_q       <= tmo_d;
         resp_q      <= resp_d;
         tmo_hit_q   <= tmo_hit_d;
         snd_cmd_q   <= snd_cmd_d;
         clr_q       <= clr_d;
         done_q      <= done_d;
         done_cmd_q  <= done_cmd_d;
         done_resp_q <= done_resp_d;
         done_err_q  <= done_err_d;
      end
   end

   assign full         = fifo_full;
   assign busy         = (state_q != S_IDLE) || !fifo_empty;
   assign snd_cmd      = snd_cmd_q;
   assign cmd          = cmd_q;
   assign data         = data_q;
   assign clr_resp_rdy = clr_q;
   assign done         = done_q;
   assign done_cmd     = done_cmd_q;
   assign done_resp    = done_resp_q;
   assign done_err     = done_err_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: a timeline model predicts every pulse,
// record and full/busy level; a scripted responder plays the copter.
module tb_cmd_sequencer;
   import quad_cmd_pkg::*;

   localparam int DEPTH = 4;
   localparam int TMO   = 100;
   localparam int MAXR  = 2;
   localparam logic [2:0] K_SND = 3'b100, K_CLR = 3'b010, K_DONE = 3'b001;

   logic        clk = 1'b0;
   logic        rst, push, frm_snt, resp_rdy;
   logic [7:0]  push_cmd, resp;
   logic [15:0] push_data;
   logic        full, busy, snd_cmd, clr_resp_rdy, done, done_err;
   logic [7:0]  cmd, done_cmd, done_resp;
   logic [15:0] data;

   cmd_sequencer #(.DEPTH(DEPTH), .TMO_CYCLES(TMO), .MAX_RETRY(MAXR)) dut (
      .clk(clk), .rst(rst), .push(push), .push_cmd(push_cmd), .push_data(push_data),
      .full(full), .busy(busy), .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
      .frm_snt(frm_snt), .resp_rdy(resp_rdy), .resp(resp), .clr_resp_rdy(clr_resp_rdy),
      .done(done), .done_cmd(done_cmd), .done_resp(done_resp), .done_err(done_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  kind;
      int          cyc;
      logic [7:0]  cmd;
      logic [15:0] data;
      logic [7:0]  resp;
      logic        err;
   } ev_t;

   typedef struct {
      int push_c;
      int load_c;
      int done_c;
   } rec_t;

   ev_t  ev_q[$];
   rec_t recs[$];
   int   rq[$];
   int   cyc = 0;
   int   rsp_dly = 2;
   int   vec_cnt = 0, err_cnt = 0;
   int   snd_total = 0, done_total = 0;
   int   last_snd = 0, prev_snd = 0, last_clr = 0, last_done = 0;
   logic [7:0] last_done_cmd, last_done_resp;
   logic       last_done_err;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- timeline model ----------------
   function automatic int occ_at(input int k);
      int n = 0;
      foreach (recs[i]) if (recs[i].push_c < k && recs[i].load_c >= k) n++;
      return n;
   endfunction

   function automatic logic fsm_active(input int k);
      foreach (recs[i]) if (recs[i].load_c <= k && k <= recs[i].done_c) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void add_ev(input logic [2:0] kind, input int c, input logic [7:0] op,
                                  input logic [15:0] d, input logic [7:0] r, input logic e);
      ev_t ev;
      ev.kind = kind; ev.cyc = c; ev.cmd = op; ev.data = d; ev.resp = r; ev.err = e;
      ev_q.push_back(ev);
   endfunction

   // Command pushed in cycle k; scr[a] is the copter's byte for attempt a, -1 = silent.
   function automatic void model_push(input logic [7:0] op, input logic [15:0] d, input int k,
                                      input int r0, input int r1, input int r2);
      int scr [3];
      int prev, s, load, m, dn;
      logic [7:0] rb;
      logic to, ok;
      rec_t rc;
      scr[0] = r0; scr[1] = r1; scr[2] = r2;
      if (occ_at(k) >= DEPTH) return;
      prev = (recs.size() > 0) ? recs[recs.size()-1].done_c : -100;
      s    = (k + 3 > prev + 3) ? k + 3 : prev + 3;
      load = s - 1;
      dn   = s;
      for (int a = 0; a <= MAXR; a++) begin
         add_ev(K_SND, s, op, d, 8'h00, 1'b0);
         rq.push_back(scr[a]);
         if (scr[a] < 0) begin
            m = s + TMO; rb = 8'h00; to = 1'b1;
         end else begin
            m = s + ((rsp_dly > 1) ? rsp_dly : 1); rb = scr[a][7:0]; to = 1'b0;
         end
         add_ev(K_CLR, m + 1, op, d, 8'h00, 1'b0);
         ok = !to && (op == REQ_BATT || rb == ACK);
         if (ok || a == MAXR) begin
            dn = m + 2;
            add_ev(K_DONE, dn, op, d, rb, !ok);
            break;
         end
         s = m + 2;
      end
      rc.push_c = k; rc.load_c = load; rc.done_c = dn;
      recs.push_back(rc);
   endfunction

   // ---------------- copter responder ----------------
   initial begin
      int   pend_val, cnt;
      logic pending;
      resp_rdy = 1'b0; resp = 8'h00; frm_snt = 1'b0; pending = 1'b0; cnt = 0; pend_val = -1;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            resp_rdy = 1'b0; pending = 1'b0; frm_snt = 1'b0;
         end else begin
            if (clr_resp_rdy) resp_rdy = 1'b0;
            if (snd_cmd) begin
               frm_snt  = 1'b0;
               pend_val = (rq.size() > 0) ? rq.pop_front() : -1;
               pending  = (pend_val >= 0);
               cnt      = rsp_dly;
            end
            if (pending) begin
               if (cnt == 0) begin
                  resp_rdy = 1'b1; resp = pend_val[7:0]; frm_snt = 1'b1; pending = 1'b0;
               end else cnt--;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   ev_t        e;
   logic [2:0] got;
   always @(negedge clk) begin
      if (!rst) begin
         got = {snd_cmd, clr_resp_rdy, done};
         check("full", full, occ_at(cyc) == DEPTH);
         check("busy", busy, (occ_at(cyc) > 0) || fsm_active(cyc));
         if (got != 3'b000) begin
            if (ev_q.size() == 0) check("unexpected_evt", got, 3'b000);
            else begin
               e = ev_q.pop_front();
               check("evt_kind", got, e.kind);
               check("evt_cyc", cyc, e.cyc);
               check("cmd", cmd, e.cmd);
               check("data", data, e.data);
               if (e.kind == K_DONE) begin
                  check("done_cmd", done_cmd, e.cmd);
                  check("done_resp", done_resp, e.resp);
                  check("done_err", done_err, e.err);
               end
            end
            if (snd_cmd) begin prev_snd = last_snd; last_snd = cyc; snd_total++; end
            if (clr_resp_rdy) last_clr = cyc;
            if (done) begin
               done_total++; last_done = cyc;
               last_done_cmd = done_cmd; last_done_resp = done_resp; last_done_err = done_err;
            end
         end else if (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
            check("missing_evt", got, ev_q[0].kind);
            void'(ev_q.pop_front());
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_push(input logic [7:0] op, input logic [15:0] d,
                          input int r0, input int r1, input int r2);
      @(posedge clk);
      #1;
      push = 1'b1; push_cmd = op; push_data = d;
      model_push(op, d, cyc, r0, r1, r2);
   endtask

   task automatic push_off();
      @(posedge clk);
      #1;
      push = 1'b0;
   endtask

   task automatic wait_done(input int n, input int budget, input string tag);
      int i = 0;
      while (done_total < n && i < budget) begin @(negedge clk); i++; end
      check(tag, done_total >= n, 1'b1);
   endtask

   task automatic wait_snd(input int n, input int budget, input string tag);
      int i = 0;
      while (snd_total < n && i < budget) begin @(negedge clk); i++; end
      check(tag, snd_total >= n, 1'b1);
   endtask

   task automatic chk_idle(input string tag);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_full"}, full, 1'b0);
      check({tag, "_pulses"}, {snd_cmd, clr_resp_rdy, done}, 3'b000);
      check({tag, "_cmd"}, cmd, 8'h00);
      check({tag, "_data"}, data, 16'h0000);
      check({tag, "_rec"}, {done_cmd, done_resp, done_err}, 17'h0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int p, n0, d0;
      rst = 1'b1; push = 1'b0; push_cmd = 8'h00; push_data = 16'h0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_idle("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // Single battery request: any reply byte is success.
      rsp_dly = 2;
      do_push(REQ_BATT, NO_DATA, 'hC0, -1, -1); p = cyc; push_off();
      wait_done(1, 50, "t1_wait");
      check("t1_snd_lat", last_snd - p, 3);
      check("t1_done_lat", last_done - p, 7);
      check("t1_resp", last_done_resp, 8'hC0);
      check("t1_err", last_done_err, 1'b0);
      check("t1_sends", snd_total, 1);

      // NAK then ACK: one retry.
      rsp_dly = 3; n0 = snd_total;
      do_push(SET_PTCH, 16'h0050, 'h00, 'hA5, -1); p = cyc; push_off();
      wait_done(2, 60, "t2_wait");
      check("t2_sends", snd_total - n0, 2);
      check("t2_resp", last_done_resp, 8'hA5);
      check("t2_err", last_done_err, 1'b0);
      check("t2_done_lat", last_done - p, 13);

      // Silent copter: three timeouts, then failure.
      rsp_dly = 2; n0 = snd_total;
      do_push(SET_THRST, 16'h0123, -1, -1, -1); p = cyc; push_off();
      wait_done(3, 400, "t3_wait");
      check("t3_sends", snd_total - n0, 3);
      check("t3_snd_gap", last_snd - prev_snd, TMO + 2);
      check("t3_resp", last_done_resp, 8'h00);
      check("t3_err", last_done_err, 1'b1);
      check("t3_done_lat", last_done - p, 309);

      // resp_rdy already high when the wait begins.
      rsp_dly = 0;
      do_push(SET_ROLL, 16'h1234, 'hA5, -1, -1); push_off();
      wait_done(4, 50, "t6_wait");
      check("t6_clr_lat", last_clr - last_snd, 2);
      check("t6_done_lat", last_done - last_snd, 3);
      check("t6_err", last_done_err, 1'b0);

      // Queue fills behind a stalled command; fifth push of the burst is dropped.
      rsp_dly = 20; n0 = done_total;
      do_push(SET_YAW, 16'h1111, 'hA5, -1, -1); push_off();
      wait_snd(snd_total + 1, 20, "t4_first_snd");
      do_push(SET_PTCH,  16'h2001, 'hA5, -1, -1);
      do_push(SET_ROLL,  16'h2002, 'hA5, -1, -1);
      do_push(EMER_LAND, 16'h2003, 'hA5, -1, -1);
      do_push(MTRS_OFF,  16'h2004, 'hA5, -1, -1);
      do_push(CALIBRATE, 16'h2005, 'hA5, -1, -1);
      @(negedge clk);
      check("t4_full", full, 1'b1);
      push_off();
      wait_done(n0 + 5, 300, "t4_wait");
      repeat (40) @(negedge clk);
      check("t4_done_count", done_total - n0, 5);
      check("t4_last_cmd", last_done_cmd, MTRS_OFF);

      // Reset during the response wait with two entries still queued.
      rsp_dly = 2; n0 = snd_total;
      do_push(SET_THRST, 16'h0AAA, -1, -1, -1);
      do_push(CALIBRATE, 16'h0BBB, 'hA5, -1, -1);
      do_push(EMER_LAND, 16'h0CCC, 'hA5, -1, -1);
      push_off();
      wait_snd(n0 + 1, 20, "t5_first_snd");
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      recs.delete(); ev_q.delete(); rq.delete();
      @(negedge clk);
      @(negedge clk);
      chk_idle("t5_rst");
      @(posedge clk);
      #1 rst = 1'b0;
      d0 = done_total;
      repeat (60) @(negedge clk);
      check("t5_no_done", done_total, d0);
      check("t5_busy", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
